// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin / fixed-priority bus arbiter.
package bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int MST_IO      = 0;
  localparam int MST_L2      = 1;
  localparam int MST_UNCACHE = 2;

  localparam int ARB_NUM_MASTERS = 3;
  // Same width as the legacy word_number bus towards uart_control / mem.
  localparam int ARB_WORD_NUM_W  = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Combinational winner selection: round-robin from a pointer, or lowest index first.
module rr_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter  int NUM_MASTERS = ARB_NUM_MASTERS,
  parameter  int PRIO_MODE   = 0,
  localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic                   o_vld,
  output logic [IDX_W-1:0]       o_idx
);

  int               w_start;
  logic             w_hi_vld;
  logic [IDX_W-1:0] w_hi_idx;

  // Descending scan keeps the lowest set index overall and the lowest at/after the
  // pointer; the latter wins, which is the wrap-around search in one pass.
  always_comb begin
    o_vld    = 1'b0;
    o_idx    = '0;
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_start  = (PRIO_MODE != 0) ? 0 : int'(i_ptr);
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'(i);
        if (i >= w_start) begin
          w_hi_vld = 1'b1;
          w_hi_idx = IDX_W'(i);
        end
      end
    end
    if (w_hi_vld) begin
      o_idx = w_hi_idx;
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter: burst-long one-hot grant, beat counting, watchdog release
// and a one-cycle turnaround between owners.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter  int NUM_MASTERS = ARB_NUM_MASTERS,
  parameter  int WORD_NUM_W  = ARB_WORD_NUM_W,
  parameter  int TIMEOUT_W   = 8,
  parameter  int TIMEOUT     = 200,
  parameter  int PRIO_MODE   = 0,
  localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS-1:0]            free,
  input  logic [NUM_MASTERS*WORD_NUM_W-1:0] burst_len,
  input  logic                              word_valid,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic [IDX_W-1:0]                  grant_id,
  output logic [WORD_NUM_W-1:0]             word_number,
  output logic [WORD_NUM_W-1:0]             beat_cnt,
  output logic                              bus_busy,
  output logic                              timeout_err
);

  arb_state_t             r_state,       w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant,       w_grant_nxt;
  logic [IDX_W-1:0]       r_grant_id,    w_gid_nxt;
  logic [WORD_NUM_W-1:0]  r_word_number, w_wn_nxt;
  logic [WORD_NUM_W-1:0]  r_beat_cnt,    w_bc_nxt;
  logic [TIMEOUT_W-1:0]   r_wdog,        w_wdog_nxt;
  logic [IDX_W-1:0]       r_ptr,         w_ptr_nxt;
  logic                   r_busy,        w_busy_nxt;
  logic                   r_terr,        w_terr_nxt;

  logic                   w_pick_vld;
  logic [IDX_W-1:0]       w_pick_idx;
  logic [NUM_MASTERS-1:0] w_pick_onehot;
  logic [WORD_NUM_W-1:0]  w_beat_inc;
  logic                   w_rel_free;
  logic                   w_rel_done;
  logic                   w_rel_to;

  function automatic logic [WORD_NUM_W-1:0] burst_words(
    input logic [NUM_MASTERS*WORD_NUM_W-1:0] bl,
    input logic [IDX_W-1:0]                  idx
  );
    logic [WORD_NUM_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (idx == IDX_W'(i)) begin
        f = bl[i*WORD_NUM_W +: WORD_NUM_W];
      end
    end
    // A zero-length field still owns the bus for one word.
    return (f == '0) ? WORD_NUM_W'(1) : f;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_MASTERS - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .PRIO_MODE   (PRIO_MODE)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

  always_comb begin
    w_pick_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_pick_onehot[i] = (w_pick_idx == IDX_W'(i));
    end
  end

  // Release causes; only the owner's free bit survives the mask with r_grant.
  assign w_beat_inc = r_beat_cnt + WORD_NUM_W'(1);
  assign w_rel_free = |(free & r_grant);
  assign w_rel_done = word_valid && (w_beat_inc == r_word_number);
  assign w_rel_to   = !word_valid && (r_wdog == TIMEOUT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gid_nxt   = r_grant_id;
    w_wn_nxt    = r_word_number;
    w_bc_nxt    = r_beat_cnt;
    w_wdog_nxt  = r_wdog;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    w_terr_nxt  = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_pick_vld) begin
          w_state_nxt = ARB_GRANT;
          w_grant_nxt = w_pick_onehot;
          w_gid_nxt   = w_pick_idx;
          w_wn_nxt    = burst_words(burst_len, w_pick_idx);
          w_bc_nxt    = '0;
          w_wdog_nxt  = '0;
          w_busy_nxt  = 1'b1;
          if (PRIO_MODE == 0) begin
            w_ptr_nxt = ptr_after(w_pick_idx);
          end
        end
      end
      ARB_GRANT: begin
        if (word_valid) begin
          w_bc_nxt   = w_beat_inc;
          w_wdog_nxt = '0;
        end else begin
          w_wdog_nxt = r_wdog + TIMEOUT_W'(1);
        end
        if (w_rel_free || w_rel_done || w_rel_to) begin
          w_state_nxt = ARB_RELEASE;
          w_grant_nxt = '0;
          w_gid_nxt   = '0;
          w_terr_nxt  = w_rel_to && !w_rel_free && !w_rel_done;
        end
      end
      ARB_RELEASE: begin
        w_state_nxt = ARB_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
        w_gid_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_word_number <= '0;
      r_beat_cnt    <= '0;
      r_wdog        <= '0;
      r_ptr         <= '0;
      r_busy        <= 1'b0;
      r_terr        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_gid_nxt;
      r_word_number <= w_wn_nxt;
      r_beat_cnt    <= w_bc_nxt;
      r_wdog        <= w_wdog_nxt;
      r_ptr         <= w_ptr_nxt;
      r_busy        <= w_busy_nxt;
      r_terr        <= w_terr_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign word_number = r_word_number;
  assign beat_cnt    = r_beat_cnt;
  assign bus_busy    = r_busy;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a round-robin instance and a fixed-priority
// instance share stimulus; TIMEOUT is 5 on both.
module tb_bus_arbiter_rr;
  import bus_arbiter_rr_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [2:0]  free;
  logic [11:0] burst_len;
  logic        word_valid;

  logic [2:0]  grant,       p_grant;
  logic [1:0]  grant_id,    p_grant_id;
  logic [3:0]  word_number, p_word_number;
  logic [3:0]  beat_cnt,    p_beat_cnt;
  logic        bus_busy,    p_bus_busy;
  logic        timeout_err, p_timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .NUM_MASTERS (3), .WORD_NUM_W (4), .TIMEOUT_W (8), .TIMEOUT (5), .PRIO_MODE (0)
  ) dut_rr (
    .clk (clk), .resetn (resetn), .req (req), .free (free), .burst_len (burst_len),
    .word_valid (word_valid), .grant (grant), .grant_id (grant_id),
    .word_number (word_number), .beat_cnt (beat_cnt), .bus_busy (bus_busy),
    .timeout_err (timeout_err)
  );

  bus_arbiter_rr #(
    .NUM_MASTERS (3), .WORD_NUM_W (4), .TIMEOUT_W (8), .TIMEOUT (5), .PRIO_MODE (1)
  ) dut_fp (
    .clk (clk), .resetn (resetn), .req (req), .free (free), .burst_len (burst_len),
    .word_valid (word_valid), .grant (p_grant), .grant_id (p_grant_id),
    .word_number (p_word_number), .beat_cnt (p_beat_cnt), .bus_busy (p_bus_busy),
    .timeout_err (p_timeout_err)
  );

  typedef struct {
    logic        rstn;
    logic [2:0]  req;
    logic [2:0]  free;
    logic [11:0] bl;
    logic        wv;
    logic [2:0]  e_grant;
    logic [1:0]  e_gid;
    logic [3:0]  e_wn;
    logic [3:0]  e_bc;
    logic        e_busy;
    logic        e_terr;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic rstn, input logic [2:0] rq, input logic [2:0] fr,
                              input logic [11:0] bl, input logic wv, input logic [2:0] g,
                              input logic [1:0] gid, input logic [3:0] wn, input logic [3:0] bc,
                              input logic busy, input logic terr);
    vec_t v;
    v.rstn = rstn; v.req = rq; v.free = fr; v.bl = bl; v.wv = wv;
    v.e_grant = g; v.e_gid = gid; v.e_wn = wn; v.e_bc = bc; v.e_busy = busy; v.e_terr = terr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; req = '0; free = '0; burst_len = '0; word_valid = 1'b0;

    //                rstn req     free    bl      wv   grant   gid wn bc busy terr
    tbl[0]  = mk(1'b0, 3'b000, 3'b000, 12'h141, 1'b0, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 3'b010, 3'b000, 12'h141, 1'b0, 3'b010, 1, 4, 0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 3'b000, 3'b000, 12'h141, 1'b1, 3'b010, 1, 4, 1, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 3'b000, 3'b000, 12'h141, 1'b1, 3'b010, 1, 4, 2, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 3'b000, 3'b000, 12'h141, 1'b1, 3'b010, 1, 4, 3, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 3'b000, 3'b000, 12'h141, 1'b1, 3'b000, 0, 4, 4, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 3'b000, 3'b000, 12'h141, 1'b0, 3'b000, 0, 4, 4, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 3'b111, 3'b000, 12'h111, 1'b0, 3'b000, 0, 0, 0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b0, 3'b001, 0, 1, 0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b1, 3'b000, 0, 1, 1, 1'b1, 1'b0);
    tbl[10] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b0, 3'b000, 0, 1, 1, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b0, 3'b010, 1, 1, 0, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b1, 3'b000, 0, 1, 1, 1'b1, 1'b0);
    tbl[13] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b0, 3'b000, 0, 1, 1, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b0, 3'b100, 2, 1, 0, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b1, 3'b000, 0, 1, 1, 1'b1, 1'b0);
    tbl[16] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b0, 3'b000, 0, 1, 1, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b0, 3'b001, 0, 1, 0, 1'b1, 1'b0);
    tbl[18] = mk(1'b1, 3'b111, 3'b000, 12'h111, 1'b1, 3'b000, 0, 1, 1, 1'b1, 1'b0);
    tbl[19] = mk(1'b1, 3'b000, 3'b000, 12'h111, 1'b0, 3'b000, 0, 1, 1, 1'b0, 1'b0);
    tbl[20] = mk(1'b1, 3'b100, 3'b000, 12'h011, 1'b0, 3'b100, 2, 1, 0, 1'b1, 1'b0);
    tbl[21] = mk(1'b1, 3'b000, 3'b000, 12'h011, 1'b1, 3'b000, 0, 1, 1, 1'b1, 1'b0);
    tbl[22] = mk(1'b1, 3'b000, 3'b000, 12'h011, 1'b0, 3'b000, 0, 1, 1, 1'b0, 1'b0);

    for (int i = 0; i < 23; i++) begin
      resetn = tbl[i].rstn; req = tbl[i].req; free = tbl[i].free;
      burst_len = tbl[i].bl; word_valid = tbl[i].wv;
      step();
      chk($sformatf("row%0d grant", i),       grant,       tbl[i].e_grant);
      chk($sformatf("row%0d grant_id", i),    grant_id,    tbl[i].e_gid);
      chk($sformatf("row%0d word_number", i), word_number, tbl[i].e_wn);
      chk($sformatf("row%0d beat_cnt", i),    beat_cnt,    tbl[i].e_bc);
      chk($sformatf("row%0d bus_busy", i),    bus_busy,    tbl[i].e_busy);
      chk($sformatf("row%0d timeout_err", i), timeout_err, tbl[i].e_terr);
    end

    // Fixed priority: master 1 wins every tenure until it drops its request.
    resetn = 1'b0; req = '0; free = '0; word_valid = 1'b0; step();
    resetn = 1'b1; req = 3'b110; burst_len = 12'h111;
    for (int t = 0; t < 3; t++) begin
      step();
      chk($sformatf("fp tenure%0d grant", t), p_grant, 3'b010);
      word_valid = 1'b1; step();
      chk($sformatf("fp tenure%0d release", t), p_grant, 3'b000);
      word_valid = 1'b0; step();
      chk($sformatf("fp tenure%0d idle busy", t), p_bus_busy, 1'b0);
    end
    req = 3'b100; step();
    chk("fp starved master grant", p_grant, 3'b100);
    chk("fp starved master id", p_grant_id, 2'd2);
    word_valid = 1'b1; req = '0; step();
    word_valid = 1'b0; step();

    // Watchdog: no beats for TIMEOUT cycles forces a release with a one-cycle error pulse.
    resetn = 1'b0; step();
    resetn = 1'b1; req = 3'b001; burst_len = 12'h118; step();
    chk("wd grant", grant, 3'b001);
    chk("wd word_number", word_number, 4'd8);
    req = 3'b010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("wd hold%0d grant", k), grant, 3'b001);
      chk($sformatf("wd hold%0d terr", k), timeout_err, 1'b0);
    end
    step();
    chk("wd forced release grant", grant, 3'b000);
    chk("wd timeout_err pulse", timeout_err, 1'b1);
    chk("wd turnaround busy", bus_busy, 1'b1);
    step();
    chk("wd pulse width", timeout_err, 1'b0);
    chk("wd idle busy", bus_busy, 1'b0);
    step();
    chk("wd next grant", grant, 3'b010);
    chk("wd next id", grant_id, 2'd1);
    req = '0; free = 3'b010; step();
    chk("wd next free release", grant, 3'b000);
    free = '0; step();

    // Free on the timeout cycle itself: plain release, no error.
    req = 3'b001; step();
    chk("free+to grant", grant, 3'b001);
    req = '0;
    for (int k = 0; k < 4; k++) step();
    free = 3'b001; step();
    chk("free+to release", grant, 3'b000);
    chk("free+to no terr", timeout_err, 1'b0);
    free = '0; step();

    // Non-owner free ignored; owner free ends the tenure early.
    req = 3'b001; burst_len = 12'h118; step();
    chk("ef grant", grant, 3'b001);
    req = '0; free = 3'b100; step();
    chk("ef foreign free ignored", grant, 3'b001);
    free = '0; word_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("ef beats", beat_cnt, 4'd3);
    chk("ef still granted", grant, 3'b001);
    word_valid = 1'b0; free = 3'b001; step();
    chk("ef release grant", grant, 3'b000);
    chk("ef release beat_cnt", beat_cnt, 4'd3);
    chk("ef no terr", timeout_err, 1'b0);
    free = '0; step();

    // Reset mid-burst clears grant, counters and the round-robin pointer.
    req = 3'b001; step();
    chk("rst grant before", grant, 3'b001);
    req = '0; word_valid = 1'b1; step(); step();
    chk("rst beat_cnt before", beat_cnt, 4'd2);
    word_valid = 1'b0; resetn = 1'b0; step();
    chk("rst grant", grant, 3'b000);
    chk("rst beat_cnt", beat_cnt, 4'd0);
    chk("rst word_number", word_number, 4'd0);
    chk("rst bus_busy", bus_busy, 1'b0);
    resetn = 1'b1; req = 3'b111; step();
    chk("rst pointer restart", grant, 3'b001);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor of the fixed three-requester bus arbiter (io / L2cache / uncache).
- Arbitrates N bus masters in round-robin or fixed-priority mode and holds a one-hot grant for a whole burst.
- Latches the winner's burst word count and drives it to the uart_control / mem path as word_number.
- Counts data beats, releases the bus on master free, burst completion or watchdog timeout, and inserts a one-cycle turnaround between owners.

Parameters:
- NUM_MASTERS, 3, number of requesters; index 0 = io, 1 = L2cache, 2 = uncache.
- WORD_NUM_W, 4, width of burst word count.
- TIMEOUT_W, 8, width of watchdog counter.
- TIMEOUT, 200, idle cycles without a beat before forced release; must be in 1..2^TIMEOUT_W-1.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous active-low reset.
- req  input  NUM_MASTERS  bus request, one bit per master.
- free  input  NUM_MASTERS  bus release, one bit per master; only the owner's bit is honoured.
- burst_len  input  NUM_MASTERS*WORD_NUM_W  per-master burst word count; master i occupies bits [i*WORD_NUM_W +: WORD_NUM_W].
- word_valid  input  1  one data beat completed on the bus this cycle.
- grant  output  NUM_MASTERS  one-hot grant; all zero when idle.
- grant_id  output  $clog2(NUM_MASTERS)  index of the current owner; 0 when idle.
- word_number  output  WORD_NUM_W  latched burst length of the owner.
- beat_cnt  output  WORD_NUM_W  beats completed in the current tenure.
- bus_busy  output  1  high in GRANT and RELEASE.
- timeout_err  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; grant=0, grant_id=0, word_number=0, beat_cnt=0, bus_busy=0, timeout_err=0; round-robin pointer=0; watchdog=0. This applies in any state, including mid-burst: the grant drops on the same edge.
- FSM states IDLE, GRANT, RELEASE; all outputs registered.
- IDLE: when req is non-zero, select a winner combinationally and register it.
  - Next cycle: state GRANT, grant[w]=1, grant_id=w, word_number=burst_len[w], or 1 when that field is 0.
  - Also clear beat_cnt and watchdog, and set bus_busy=1.
  - Latency from req to grant is 1 cycle.
- Round-robin: search starts at the pointer and wraps modulo NUM_MASTERS. On each grant the pointer becomes w+1, wrapping to 0 after NUM_MASTERS-1.
- Fixed priority: the lowest set index wins; the pointer is unused.
- GRANT: the grant is held regardless of req changes; deasserting req does not release the bus.
  - On word_valid: beat_cnt+1, watchdog cleared. Without word_valid: watchdog+1.
  - Release conditions, evaluated each cycle:
    - (a) free[owner]=1;
    - (b) word_valid=1 and beat_cnt+1 == word_number;
    - (c) watchdog reaches TIMEOUT-1 with no word_valid, which forces release and pulses timeout_err for 1 cycle.
  - Any release moves to RELEASE with grant=0 on the next edge.
  - Simultaneous (a), (b) and (c): a single release; timeout_err is asserted only if (c) holds and neither (a) nor (b) does.
  - free bits of non-owners are ignored.
  - word_valid beyond word_number cannot occur, since (b) releases first; beat_cnt never wraps.
- RELEASE: exactly 1 cycle with grant=0 and bus_busy=1, then IDLE with bus_busy=0. A req seen in IDLE is granted the following cycle, so the minimum gap between owners is 2 cycles.
- word_number and beat_cnt hold their last values in RELEASE and IDLE until the next grant.
- The grant is always one-hot or zero; no cycle has two bits set.

Decomposition:
- Shared package holds:
  - state encoding (ARB_IDLE, ARB_GRANT, ARB_RELEASE);
  - master index constants (MST_IO=0, MST_L2=1, MST_UNCACHE=2);
  - the default WORD_NUM_W, matching the existing word-number bus width.
- One sub-module, rr_pick: combinational next-winner selection from req, pointer and PRIO_MODE, outputting a valid flag and an index.
- Counters and FSM stay in the top.

Test Plan:
- Single request (N=3, RR): req=3'b010, burst_len[1]=4, 4 word_valid pulses → grant=3'b010 one cycle after req; word_number=4; beat_cnt reaches 4; grant drops after the 4th beat; 1 turnaround cycle, then bus_busy=0.
- Round-robin fairness: req=3'b111 held, each master bursts 1 word → grant order 001, 010, 100, 001, with a 2-cycle gap between grants.
- Fixed priority (PRIO_MODE=1): req=3'b110 held → master 1 is granted every tenure; master 2 starves until req[1]=0.
- Early free and ignored free: owner 0 with burst_len=8; free[2] pulsed first, then free[0] after 3 beats → no effect from free[2]; release on free[0] with beat_cnt=3; no timeout_err.
- Watchdog (TIMEOUT=5): grant with no word_valid → forced release on the 5th idle cycle, timeout_err high for exactly 1 cycle; next requester granted afterwards.
- Reset mid-burst: resetn=0 during GRANT with beat_cnt=2 → next edge: grant=0, beat_cnt=0, word_number=0, pointer=0; after resetn=1 with req=3'b111, master 0 is granted first.
